// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single memory controller port.
// Latency: request seen in IDLE at cycle N is presented to memory at N+1; ready is combinational from mem_ready.
// Backpressure: one transaction in flight; requesters hold until their ready pulse, watchdog ends stalled accesses with err.
module mem_bus_arbiter #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  input  logic        m0_we,
  input  logic        m0_re,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  output logic        m0_err,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_we,
  input  logic        m1_re,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        m1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [1:0]  grant
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  // Counter value seen on the last permitted BUSY cycle.
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last;

  logic        req0, req1, pick;
  logic        timeout_hit, done;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        sel_we, sel_re;

  assign req0 = m0_we | m0_re;
  assign req1 = m1_we | m1_re;

  // On a tie the master that did not win last time gets the bus.
  assign pick = (req0 && req1) ? ~last : req1;

  assign sel_addr  = pick ? m1_addr  : m0_addr;
  assign sel_wdata = pick ? m1_wdata : m0_wdata;
  assign sel_wstrb = pick ? m1_wstrb : m0_wstrb;
  assign sel_we    = pick ? m1_we    : m0_we;
  assign sel_re    = pick ? m1_re    : m0_re;

  // A controller completion in the same cycle as the watchdog takes precedence.
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
  assign done        = (state == BUSY) && (mem_ready || timeout_hit);

  // Arbitration FSM: latch one request, hold it until completion or watchdog expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      grant     <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state     <= BUSY;
            cnt       <= '0;
            last      <= pick;
            grant     <= pick ? 2'b10 : 2'b01;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_wstrb <= sel_wstrb;
            // A simultaneous write and read request is carried out as a write.
            mem_we    <= sel_we;
            mem_re    <= sel_re & ~sel_we;
          end
        end
        BUSY: begin
          if (done) begin
            state  <= IDLE;
            grant  <= 2'b00;
            mem_we <= 1'b0;
            mem_re <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion routing back to the owner; non-owners see all zeros.
  always_comb begin
    m0_ready = done & grant[0];
    m1_ready = done & grant[1];
    m0_err   = m0_ready & ~mem_ready;
    m1_err   = m1_ready & ~mem_ready;
    m0_rdata = '0;
    m1_rdata = '0;
    if (m0_ready) m0_rdata = mem_ready ? mem_rdata : ERR_DATA;
    if (m1_ready) m1_rdata = mem_ready ? mem_rdata : ERR_DATA;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_we, m0_re, m1_we, m1_re;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m0_err, m1_ready, m1_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_we, mem_re, mem_ready;
  logic [1:0]  grant;

  int errors = 0;
  int checks = 0;

  mem_bus_arbiter #(.TIMEOUT(TO), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_we(m0_we), .m0_re(m0_re),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_we(m1_we), .m1_re(m1_re),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant(grant)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL sim_time_limit: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    m0_addr = '0; m0_wdata = '0; m0_wstrb = '0; m0_we = 0; m0_re = 0;
    m1_addr = '0; m1_wdata = '0; m1_wstrb = '0; m1_we = 0; m1_re = 0;
    mem_rdata = '0; mem_ready = 0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rst;
    logic        m0_we, m0_re;
    logic [31:0] m0_addr, m0_wdata;
    logic [3:0]  m0_wstrb;
    logic        m1_we, m1_re;
    logic [31:0] m1_addr;
    logic        mr;
    logic [31:0] mrd;
    logic [1:0]  e_grant;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic        e_we, e_re;
    logic [1:0]  e_m0;      // {ready, err}
    logic [31:0] e_m0_rdata;
    logic [1:0]  e_m1;
    logic [31:0] e_m1_rdata;
  } vec_t;

  vec_t vecs[13];

  // Random-test state: stimulus per master and the reference model.
  logic        s_we[2], s_re[2], pend[2], ack[2];
  logic [31:0] s_addr[2], s_wdata[2];
  logic [3:0]  s_wstrb[2];
  logic        md_busy, md_last, md_we, md_re, md_done;
  int          md_owner, md_cnt;
  logic [31:0] md_addr, md_wdata;
  logic [3:0]  md_wstrb;
  logic        e_rdy[2], e_err[2];
  logic [31:0] e_rd[2];

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("reset_grant", 80'(grant), 80'd0);
    chk("reset_mem", 80'({mem_addr, mem_wdata, mem_wstrb, mem_we, mem_re}), 80'd0);
    chk("reset_m", 80'({m0_ready, m0_err, m0_rdata, m1_ready, m1_err, m1_rdata}), 80'd0);

    //         rst m0we re  m0addr        m0wdata       strb  m1we re m1addr       mr  mrd            grant  e_addr        e_wdata       e_strb we re  e_m0   e_m0_rdata     e_m1   e_m1_rdata
    vecs[0]  = '{1, 0, 1, 32'h100, 32'h0,        4'h0, 0, 0, 32'h0,  1, 32'h12345678, 2'b00, 32'h0,   32'h0,        4'h0, 0, 0, 2'b00, 32'h0,        2'b00, 32'h0};
    vecs[1]  = '{0, 0, 1, 32'h100, 32'h0,        4'h0, 0, 0, 32'h0,  1, 32'h12345678, 2'b01, 32'h100, 32'h0,        4'h0, 0, 1, 2'b10, 32'h12345678, 2'b00, 32'h0};
    vecs[2]  = '{0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 32'h0,  1, 32'h12345678, 2'b00, 32'h100, 32'h0,        4'h0, 0, 0, 2'b00, 32'h0,        2'b00, 32'h0};
    vecs[3]  = '{1, 1, 0, 32'h10,  32'h11111111, 4'hf, 0, 1, 32'h20, 1, 32'hCAFE0001, 2'b00, 32'h0,   32'h0,        4'h0, 0, 0, 2'b00, 32'h0,        2'b00, 32'h0};
    vecs[4]  = '{0, 1, 0, 32'h10,  32'h11111111, 4'hf, 0, 1, 32'h20, 1, 32'hCAFE0001, 2'b01, 32'h10,  32'h11111111, 4'hf, 1, 0, 2'b10, 32'hCAFE0001, 2'b00, 32'h0};
    vecs[5]  = '{0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 1, 32'h20, 1, 32'hCAFE0001, 2'b00, 32'h10,  32'h11111111, 4'hf, 0, 0, 2'b00, 32'h0,        2'b00, 32'h0};
    vecs[6]  = '{0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 1, 32'h20, 1, 32'hCAFE0001, 2'b10, 32'h20,  32'h0,        4'h0, 0, 1, 2'b00, 32'h0,        2'b10, 32'hCAFE0001};
    vecs[7]  = '{0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 32'h0,  1, 32'hCAFE0001, 2'b00, 32'h20,  32'h0,        4'h0, 0, 0, 2'b00, 32'h0,        2'b00, 32'h0};
    vecs[8]  = '{0, 0, 1, 32'h30,  32'h0,        4'h0, 0, 1, 32'h40, 1, 32'hCAFE0001, 2'b00, 32'h20,  32'h0,        4'h0, 0, 0, 2'b00, 32'h0,        2'b00, 32'h0};
    vecs[9]  = '{0, 0, 1, 32'h30,  32'h0,        4'h0, 0, 1, 32'h40, 1, 32'hCAFE0001, 2'b01, 32'h30,  32'h0,        4'h0, 0, 1, 2'b10, 32'hCAFE0001, 2'b00, 32'h0};
    vecs[10] = '{1, 1, 1, 32'h50,  32'h55AA,     4'h3, 0, 0, 32'h0,  0, 32'h0,        2'b00, 32'h0,   32'h0,        4'h0, 0, 0, 2'b00, 32'h0,        2'b00, 32'h0};
    vecs[11] = '{0, 1, 1, 32'h50,  32'h55AA,     4'h3, 0, 0, 32'h0,  0, 32'h0,        2'b01, 32'h50,  32'h55AA,     4'h3, 1, 0, 2'b00, 32'h0,        2'b00, 32'h0};
    vecs[12] = '{0, 1, 1, 32'h50,  32'h55AA,     4'h3, 0, 0, 32'h0,  1, 32'h77,       2'b01, 32'h50,  32'h55AA,     4'h3, 1, 0, 2'b10, 32'h77,       2'b00, 32'h0};

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].rst) do_reset();
      m0_we = vecs[i].m0_we; m0_re = vecs[i].m0_re; m0_addr = vecs[i].m0_addr;
      m0_wdata = vecs[i].m0_wdata; m0_wstrb = vecs[i].m0_wstrb;
      m1_we = vecs[i].m1_we; m1_re = vecs[i].m1_re; m1_addr = vecs[i].m1_addr;
      m1_wdata = '0; m1_wstrb = '0;
      mem_ready = vecs[i].mr; mem_rdata = vecs[i].mrd;
      #2;
      chk($sformatf("v%0d_grant", i), 80'(grant), 80'(vecs[i].e_grant));
      chk($sformatf("v%0d_mem_addr", i), 80'(mem_addr), 80'(vecs[i].e_addr));
      chk($sformatf("v%0d_mem_wdata", i), 80'(mem_wdata), 80'(vecs[i].e_wdata));
      chk($sformatf("v%0d_mem_wstrb", i), 80'(mem_wstrb), 80'(vecs[i].e_wstrb));
      chk($sformatf("v%0d_mem_we_re", i), 80'({mem_we, mem_re}), 80'({vecs[i].e_we, vecs[i].e_re}));
      chk($sformatf("v%0d_m0_rdy_err", i), 80'({m0_ready, m0_err}), 80'(vecs[i].e_m0));
      chk($sformatf("v%0d_m0_rdata", i), 80'(m0_rdata), 80'(vecs[i].e_m0_rdata));
      chk($sformatf("v%0d_m1_rdy_err", i), 80'({m1_ready, m1_err}), 80'(vecs[i].e_m1));
      chk($sformatf("v%0d_m1_rdata", i), 80'(m1_rdata), 80'(vecs[i].e_m1_rdata));
      tick();
    end

    // Latching: master 1 changes its address while the access waits 3 cycles.
    idle_inputs();
    do_reset();
    m1_re = 1; m1_addr = 32'h20;
    tick();
    for (int w = 0; w < 3; w++) begin
      if (w == 0) m1_addr = 32'h40;
      #2;
      chk("latch_addr_wait", 80'(mem_addr), 80'h20);
      chk("latch_no_ready", 80'({m1_ready, m0_ready}), 80'd0);
      tick();
    end
    mem_ready = 1; mem_rdata = 32'hBEEF0002;
    #2;
    chk("latch_addr_done", 80'(mem_addr), 80'h20);
    chk("latch_m1_done", 80'({m1_ready, m1_err, m1_rdata}), 80'({2'b10, 32'hBEEF0002}));
    tick();
    m1_re = 0; mem_ready = 0;

    // Watchdog: no controller response, fires on the 8th BUSY cycle.
    idle_inputs();
    do_reset();
    m0_re = 1; m0_addr = 32'h80;
    tick();
    for (int b = 1; b < TO; b++) begin
      #2;
      chk($sformatf("wd_wait%0d", b), 80'({m0_ready, m0_err}), 80'd0);
      tick();
    end
    #2;
    chk("wd_fire", 80'({m0_ready, m0_err, m0_rdata}), 80'({2'b11, 32'hDEADBEEF}));
    chk("wd_fire_grant", 80'(grant), 80'h1);
    tick();
    m0_re = 0;
    #2;
    chk("wd_idle_grant", 80'(grant), 80'd0);
    chk("wd_idle_mem_re", 80'(mem_re), 80'd0);
    tick();
    // Same again, but the controller answers on the deadline cycle.
    m0_re = 1;
    tick();
    repeat (TO - 1) tick();
    mem_ready = 1; mem_rdata = 32'h600DF00D;
    #2;
    chk("wd_tie_mem_wins", 80'({m0_ready, m0_err, m0_rdata}), 80'({2'b10, 32'h600DF00D}));
    tick();
    m0_re = 0; mem_ready = 0;

    // Reset while BUSY: outputs clear without a clock edge and no ready escapes.
    idle_inputs();
    do_reset();
    m0_re = 1; m0_addr = 32'h90;
    tick();
    tick();
    #2;
    rst_n = 0;
    mem_ready = 1;
    #1;
    chk("arst_grant", 80'(grant), 80'd0);
    chk("arst_mem", 80'({mem_addr, mem_we, mem_re}), 80'd0);
    chk("arst_m0", 80'({m0_ready, m0_err, m0_rdata}), 80'd0);
    tick();
    rst_n = 1;
    m0_re = 1; m0_addr = 32'hA0; m1_re = 1; m1_addr = 32'hB0;
    #2;
    chk("arst_after_idle", 80'({m0_ready, m1_ready, grant}), 80'd0);
    tick();
    #2;
    chk("arst_tie_grant", 80'(grant), 80'h1);
    chk("arst_tie_addr", 80'(mem_addr), 80'hA0);
    tick();
    idle_inputs();
    tick();

    // Randomized traffic against a transaction-level reference model.
    do_reset();
    md_busy = 0; md_last = 1; md_owner = 0; md_cnt = 0;
    md_addr = '0; md_wdata = '0; md_wstrb = '0; md_we = 0; md_re = 0;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 0; ack[m] = 0; s_we[m] = 0; s_re[m] = 0;
      s_addr[m] = '0; s_wdata[m] = '0; s_wstrb[m] = '0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (ack[m]) begin
          pend[m] = 0; s_we[m] = 0; s_re[m] = 0;
        end else if (!pend[m] && ($urandom_range(2) == 0)) begin
          int op;
          op = $urandom_range(2);
          pend[m] = 1;
          s_we[m] = (op != 0);
          s_re[m] = (op != 1);
          s_addr[m] = $urandom; s_wdata[m] = $urandom; s_wstrb[m] = 4'($urandom);
        end
      end
      m0_we = s_we[0]; m0_re = s_re[0]; m0_addr = s_addr[0]; m0_wdata = s_wdata[0]; m0_wstrb = s_wstrb[0];
      m1_we = s_we[1]; m1_re = s_re[1]; m1_addr = s_addr[1]; m1_wdata = s_wdata[1]; m1_wstrb = s_wstrb[1];
      mem_ready = ($urandom_range(3) == 0);
      mem_rdata = $urandom;
      #2;
      md_done = md_busy && (mem_ready || (md_cnt == TO - 1));
      for (int m = 0; m < 2; m++) begin
        e_rdy[m] = md_done && (md_owner == m);
        e_err[m] = e_rdy[m] && !mem_ready;
        e_rd[m]  = e_rdy[m] ? (mem_ready ? mem_rdata : 32'hDEADBEEF) : 32'h0;
        ack[m]   = e_rdy[m];
      end
      chk("rnd_grant", 80'(grant), md_busy ? ((md_owner == 1) ? 80'h2 : 80'h1) : 80'h0);
      chk("rnd_mem", 80'({mem_addr, mem_wdata, mem_wstrb, mem_we, mem_re}),
          80'({md_addr, md_wdata, md_wstrb, md_we, md_re}));
      chk("rnd_m0", 80'({m0_ready, m0_err, m0_rdata}), 80'({e_rdy[0], e_err[0], e_rd[0]}));
      chk("rnd_m1", 80'({m1_ready, m1_err, m1_rdata}), 80'({e_rdy[1], e_err[1], e_rd[1]}));
      @(posedge clk);
      if (!md_busy) begin
        logic r0, r1;
        int   w;
        r0 = s_we[0] | s_re[0];
        r1 = s_we[1] | s_re[1];
        if (r0 || r1) begin
          // Contention goes to whoever did not win the previous grant.
          w = (r0 && r1) ? (md_last ? 0 : 1) : (r1 ? 1 : 0);
          md_owner = w; md_last = (w == 1); md_busy = 1; md_cnt = 0;
          md_addr = s_addr[w]; md_wdata = s_wdata[w]; md_wstrb = s_wstrb[w];
          md_we = s_we[w]; md_re = s_re[w] && !s_we[w];
        end
      end else if (md_done) begin
        md_busy = 0; md_we = 0; md_re = 0;
      end else begin
        md_cnt++;
      end
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter sharing the single memory controller port between the RISC-V core (master 0) and a second requester such as the debug/loader or DMA port (master 1). It sits between the virtual system's memory interface and the memory controller. It latches one request at a time, issues it to the controller, and routes the response back to the granted master. Grants use round-robin priority. A per-transaction watchdog completes stalled accesses with an error.

## Interface
- TIMEOUT, 255: maximum cycles in BUSY waiting for mem_ready; 0 disables the watchdog.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on a timed-out access.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- m0_addr / m1_addr  input  32  request address.
- m0_wdata / m1_wdata  input  32  write data.
- m0_wstrb / m1_wstrb  input  4  byte write strobes.
- m0_we / m1_we  input  1  write request.
- m0_re / m1_re  input  1  read request.
- m0_rdata / m1_rdata  output  32  read data, valid only while the matching m*_ready is high.
- m0_ready / m1_ready  output  1  one-cycle completion pulse.
- m0_err / m1_err  output  1  pulses with m*_ready when the access timed out.
- mem_addr, mem_wdata  output  32  registered request to the memory controller.
- mem_wstrb  output  4  registered strobes.
- mem_we, mem_re  output  1  registered request strobes.
- mem_rdata  input  32  controller read data.
- mem_ready  input  1  controller completion.
- grant  output  2  one-hot current owner; 2'b00 when idle.

## Operation
- Master request: a master requests when `req_i = m_i_we | m_i_re`. The master holds its request until it sees m_i_ready, then deasserts it on the next cycle.
- State IDLE:
  - If no master is requesting, remain in IDLE.
  - If exactly one master is requesting, grant that master.
  - If both request, grant the master that did not win last. The `last` register resets to 1, so master 0 wins the first tie.
  - On grant, latch addr, wdata, wstrb, we, and re into the mem_* registers, set grant, clear the timeout counter, update `last`, and go to BUSY.
  - If both we and re are high on the granted master, perform a write (mem_we=1, mem_re=0).
- State BUSY: hold the mem_* outputs constant. Changes on the master inputs are ignored because the request is already latched. The counter increments every cycle.
  - If mem_ready=1: combinationally assert ready for the granted master and route mem_rdata to its rdata. Clear mem_we/mem_re and grant, and go to IDLE.
  - Else if TIMEOUT≠0 and counter==TIMEOUT-1: assert the granted master's ready and err, drive rdata=ERR_DATA, clear the mem strobes, and go to IDLE.
  - If mem_ready and the timeout coincide, mem_ready wins and err stays 0.
- Non-granted masters: ready and err stay 0; rdata reads 0.
- Reset: may be asserted mid-transaction. All state clears immediately; no ready pulse is generated for the aborted access.
- Reset values:
  - All outputs are 0: mem_*, m*_ready, m*_err, m*_rdata, grant.
  - State is IDLE, counter is 0, `last` is 1.
- Counter width is $clog2(TIMEOUT+1), minimum 1 bit.

## Timing
- Request first seen in IDLE at cycle N: grant and the mem_* outputs are valid from cycle N+1.
- Zero-wait controller (mem_ready high at N+1): m_i_ready pulses in N+1, and the arbiter is back in IDLE at N+2.
- Arbitration turnaround is one IDLE cycle.
  - Back-to-back requests from alternating masters reach the memory at N+1, N+3, N+5, …
  - Each transaction occupies a minimum of 2 cycles.
- Ready pulse: m*_ready is exactly 1 cycle wide and never overlaps between masters.
- Timeout: asserted on the TIMEOUT-th BUSY cycle, i.e. cycle N+TIMEOUT.
- The mem_ready → m*_ready/m*_rdata path is combinational; every other output is registered.

## Test plan
- Read by master 0, zero-wait: m0_re=1, addr=0x100, mem_rdata=0x12345678, mem_ready tied 1.
  - mem_re=1 and mem_addr=0x100 appear one cycle later.
  - m0_ready pulses in that same cycle with m0_rdata=0x12345678, m1_ready=0.
- Simultaneous requests after reset: m0_we (addr 0x10) and m1_re (addr 0x20) held.
  - Master 0 is granted first (write to 0x10), then master 1 (read of 0x20).
  - The next tie goes to master 0 again.
- Latching: change m1_addr from 0x20 to 0x40 while BUSY with 3 wait states.
  - mem_addr stays 0x20 for the whole transaction.
- Watchdog with TIMEOUT=8 and mem_ready held 0:
  - m0_ready and m0_err pulse on the 8th BUSY cycle with m0_rdata=0xDEADBEEF.
  - Repeat with mem_ready asserted in that same cycle: err=0 and rdata=mem_rdata.
- Reset mid-transaction: assert rst_n=0 while BUSY.
  - All outputs go to 0 asynchronously and no ready pulse occurs.
  - After release, a tie is again won by master 0.
- Both strobes: m0_we=m0_re=1 with wstrb=4'b0011.
  - Produces mem_we=1, mem_re=0, mem_wstrb=4'b0011.
